// File: rtl/axis_mem_stream_driver.sv
// AXI-Stream burst writer/checker: writes a generated pattern, reads it back and compares it.
// Build option: define PATTERN_LFSR_EN to use a 32-bit Galois LFSR pattern instead of increment.
module axis_mem_stream_driver #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 12,
   parameter logic [31:0] SEED       = 32'h0000_0055
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic                    start,
   input  logic [CNT_WIDTH-1:0]    burst_len,
   output logic [DATA_WIDTH-1:0]   m01_axis_wr_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   input  logic                    m01_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s01_axis_rd_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_WIDTH-1:0]    err_count,
   output logic                    tlast_err
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

`ifdef PATTERN_LFSR_EN
   localparam logic [DATA_WIDTH-1:0] SeedVal =
      (SEED == 32'd0) ? DATA_WIDTH'(1) : DATA_WIDTH'(SEED);

   function automatic logic [DATA_WIDTH-1:0] next_pat(input logic [DATA_WIDTH-1:0] cur);
      return (cur >> 1) ^ (cur[0] ? DATA_WIDTH'(32'h8020_0003) : '0);
   endfunction
`else
   localparam logic [DATA_WIDTH-1:0] SeedVal = DATA_WIDTH'(SEED);

   function automatic logic [DATA_WIDTH-1:0] next_pat(input logic [DATA_WIDTH-1:0] cur);
      return cur + DATA_WIDTH'(1);
   endfunction
`endif

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

   state_e                  state_q;
   logic [CNT_WIDTH-1:0]    len_q, wr_idx_q, rd_idx_q, err_q;
   logic [DATA_WIDTH-1:0]   wr_pat_q, rd_pat_q;
   logic                    m_tvalid_q, m_tlast_q, s_tready_q, busy_q, done_q, tlast_err_q;

   logic [CNT_WIDTH-1:0]    len_m1;
   logic                    wr_last, wr_next_last, rd_last;
   logic                    unused_tstrb;

   assign len_m1       = len_q - CNT_WIDTH'(1);
   assign wr_last      = (wr_idx_q == len_m1);
   assign wr_next_last = ((wr_idx_q + CNT_WIDTH'(1)) == len_m1);
   assign rd_last      = (rd_idx_q == len_m1);
   assign unused_tstrb = ^s01_axis_tstrb;

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         err_q       <= '0;
         wr_pat_q    <= SeedVal;
         rd_pat_q    <= SeedVal;
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         s_tready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tlast_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q       <= burst_len;
                  wr_idx_q    <= '0;
                  rd_idx_q    <= '0;
                  err_q       <= '0;
                  tlast_err_q <= 1'b0;
                  wr_pat_q    <= SeedVal;
                  rd_pat_q    <= SeedVal;
                  if (burst_len != '0) begin
                     state_q    <= StWrite;
                     m_tvalid_q <= 1'b1;
                     m_tlast_q  <= (burst_len == CNT_WIDTH'(1));
                     busy_q     <= 1'b1;
                  end else begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StWrite: begin
               if (m01_axis_tready) begin
                  wr_idx_q <= wr_idx_q + CNT_WIDTH'(1);
                  wr_pat_q <= next_pat(wr_pat_q);
                  if (wr_last) begin
                     state_q    <= StRead;
                     m_tvalid_q <= 1'b0;
                     m_tlast_q  <= 1'b0;
                     s_tready_q <= 1'b1;
                  end else begin
                     m_tlast_q <= wr_next_last;
                  end
               end
            end
            StRead: begin
               // s_tready_q is always high here, so tvalid alone marks a transfer
               if (s01_axis_tvalid) begin
                  if ((s01_axis_rd_tdata != rd_pat_q) && (err_q != '1)) begin
                     err_q <= err_q + CNT_WIDTH'(1);
                  end
                  if (s01_axis_tlast != rd_last) begin
                     tlast_err_q <= 1'b1;
                  end
                  rd_idx_q <= rd_idx_q + CNT_WIDTH'(1);
                  rd_pat_q <= next_pat(rd_pat_q);
                  if (rd_last) begin
                     state_q    <= StDone;
                     s_tready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign m01_axis_wr_tdata = m_tvalid_q ? wr_pat_q : '0;
   assign m01_axis_tstrb    = {StrbWidth{m_tvalid_q}};
   assign m01_axis_tvalid   = m_tvalid_q;
   assign m01_axis_tlast    = m_tlast_q;
   assign s01_axis_tready   = s_tready_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign err_count         = err_q;
   assign tlast_err         = tlast_err_q;

endmodule

// File: tb/tb_axis_mem_stream_driver.sv
// Bench for axis_mem_stream_driver: loopback FIFO memory model with random stalls,
// corrupted data/tlast injection, zero-length bursts and mid-burst reset.
module tb_axis_mem_stream_driver;

   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 12;
   localparam logic [31:0] SEED = 32'h0000_0055;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] burst_len = '0;
   logic [DW-1:0] m_tdata;
   logic [3:0]    m_tstrb;
   logic          m_tvalid, m_tlast;
   logic          m_tready = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [3:0]    s_tstrb = '0;
   logic          s_tvalid = 1'b0, s_tlast = 1'b0;
   logic          s_tready, busy, done, tlast_err;
   logic [CW-1:0] err_count;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] fifo[$];

   axis_mem_stream_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SEED(SEED)) dut (
      .axis_aclk(clk), .axis_areset(rst), .start(start), .burst_len(burst_len),
      .m01_axis_wr_tdata(m_tdata), .m01_axis_tstrb(m_tstrb), .m01_axis_tvalid(m_tvalid),
      .m01_axis_tlast(m_tlast), .m01_axis_tready(m_tready),
      .s01_axis_rd_tdata(s_tdata), .s01_axis_tstrb(s_tstrb), .s01_axis_tvalid(s_tvalid),
      .s01_axis_tlast(s_tlast), .s01_axis_tready(s_tready),
      .busy(busy), .done(done), .err_count(err_count), .tlast_err(tlast_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Word k of the stream, derived directly from the pattern rules
   function automatic logic [DW-1:0] pat(input int k);
      logic [DW-1:0] p;
`ifdef PATTERN_LFSR_EN
      p = (SEED == 32'd0) ? 32'd1 : SEED;
      for (int i = 0; i < k; i++) p = (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'd0);
`else
      p = SEED + 32'(k);
`endif
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input int len, input int stall_pct, input int bad_data_idx,
                            input int bad_last_idx, input bit poke_start);
      int k, j, cyc;
      int exp_err;
      bit exp_tlerr, v, tl;
      logic [DW-1:0] d;
      exp_err = 0;
      exp_tlerr = 0;
      fifo.delete();
      @(negedge clk);
      start = 1'b1;
      burst_len = CW'(len);
      @(negedge clk);
      start = 1'b0;
      if (len == 0) begin
         chk("len0_done", done, 1);
         chk("len0_busy", busy, 0);
         chk("len0_tvalid", m_tvalid, 0);
         chk("len0_tready", s_tready, 0);
         @(negedge clk);
         chk("len0_done_clr", done, 0);
         chk("len0_tvalid2", m_tvalid, 0);
         return;
      end
      k = 0;
      cyc = 0;
      while (k < len && cyc < 1000) begin
         chk("wr_busy", busy, 1);
         chk("wr_tvalid", m_tvalid, 1);
         chk("wr_tdata", m_tdata, pat(k));
         chk("wr_tlast", m_tlast, (k == len - 1));
         chk("wr_tstrb", m_tstrb, 4'hf);
         chk("wr_s_tready", s_tready, 0);
         chk("wr_done", done, 0);
         m_tready = ($urandom_range(99) >= stall_pct);
         if (poke_start) begin
            start = 1'($urandom_range(1));
            burst_len = CW'($urandom_range(7));
         end
         if (m_tready) begin
            fifo.push_back(m_tdata);
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 1000) chk("wr_timeout", 0, 1);
      start = 1'b0;
      m_tready = 1'b0;
      j = 0;
      cyc = 0;
      while (j < len && cyc < 1000) begin
         chk("rd_s_tready", s_tready, 1);
         chk("rd_m_tvalid", m_tvalid, 0);
         chk("rd_m_tdata", m_tdata, 0);
         chk("rd_busy", busy, 1);
         chk("rd_done", done, 0);
         v = ($urandom_range(3) != 0);
         s_tvalid = v;
         s_tdata = $urandom;
         s_tlast = 1'($urandom_range(1));
         if (v) begin
            d = fifo.pop_front();
            if (j == bad_data_idx) d = '0;
            tl = (j == len - 1) ^ (j == bad_last_idx);
            s_tdata = d;
            s_tlast = tl;
            if (d != pat(j) && exp_err < (1 << CW) - 1) exp_err++;
            if (tl != (j == len - 1)) exp_tlerr = 1;
         end
         @(negedge clk);
         if (v) j++;
         cyc++;
      end
      if (cyc >= 1000) chk("rd_timeout", 0, 1);
      // Offer one extra beat; it must not be accepted
      s_tvalid = 1'b1;
      s_tdata = $urandom;
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_s_tready", s_tready, 0);
      chk("end_m_tvalid", m_tvalid, 0);
      chk("end_err_count", err_count, exp_err);
      chk("end_tlast_err", tlast_err, exp_tlerr);
      @(negedge clk);
      s_tvalid = 1'b0;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_s_tready", s_tready, 0);
      chk("post_err_count", err_count, exp_err);
      chk("post_tlast_err", tlast_err, exp_tlerr);
   endtask

   initial begin
      int len, bad;
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tstrb", m_tstrb, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_count, 0);
      chk("rst_tlast_err", tlast_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_burst(3, 0, -1, -1, 1'b0);
      run_burst(4, 50, -1, -1, 1'b1);
      run_burst(3, 0, 1, -1, 1'b0);
      run_burst(3, 30, -1, 1, 1'b0);
      run_burst(0, 0, -1, -1, 1'b0);

      // Reset mid-write after two of five beats
      @(negedge clk);
      start = 1'b1;
      burst_len = CW'(5);
      m_tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_wr0", m_tdata, pat(0));
      @(negedge clk);
      chk("mid_wr1", m_tdata, pat(1));
      @(negedge clk);
      chk("mid_wr2", m_tdata, pat(2));
      rst = 1'b1;
      #1;
      chk("mid_rst_tvalid", m_tvalid, 0);
      chk("mid_rst_tdata", m_tdata, 0);
      chk("mid_rst_busy", busy, 0);
      m_tready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("idle_tvalid", m_tvalid, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
      end
      run_burst(2, 0, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         len = $urandom_range(1, 9);
         bad = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, len - 1)) : -1;
         run_burst(len, $urandom_range(0, 60), bad,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                   1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
